// File: rtl/moore_seq_gen_1001.sv
// Serial pattern transmitter: shifts a fixed W-bit pattern out MSB first, a
// programmable number of times, with programmable idle gaps between repeats.
module moore_seq_gen_1001 #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  PATTERN = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count,
    input  logic [1:0] gap,
    output logic       x,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned IW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [3:0]    r_rep;
    logic [1:0]    r_gap;
    logic [1:0]    r_gap_cnt;
    logic          r_x;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state_n;
    logic [IW-1:0] w_idx_n;
    logic [3:0]    w_rep_n;
    logic [1:0]    w_gap_n;
    logic [1:0]    w_gap_cnt_n;
    logic          w_x_n;
    logic          w_valid_n;
    logic          w_busy_n;
    logic          w_done_n;

    // State, counters and outputs; outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_x       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_rep     <= w_rep_n;
            r_gap     <= w_gap_n;
            r_gap_cnt <= w_gap_cnt_n;
            r_x       <= w_x_n;
            r_valid   <= w_valid_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
        end
    end

    // r_rep holds the repetitions still to send, including the current one.
    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_rep_n     = r_rep;
        w_gap_n     = r_gap;
        w_gap_cnt_n = r_gap_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count != 4'd0) begin
                        w_rep_n   = count;
                        w_gap_n   = gap;
                        w_idx_n   = IW'(W - 1);
                        w_state_n = S_SEND;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (r_idx == '0) begin
                    if (r_rep > 4'd1) begin
                        w_rep_n = r_rep - 4'd1;
                        if (r_gap != 2'd0) begin
                            w_gap_cnt_n = r_gap - 2'd1;
                            w_state_n   = S_GAP;
                        end else begin
                            w_idx_n = IW'(W - 1);
                        end
                    end else begin
                        w_rep_n   = 4'd0;
                        w_state_n = S_DONE;
                    end
                end else begin
                    w_idx_n = r_idx - 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 2'd0) begin
                    w_idx_n   = IW'(W - 1);
                    w_state_n = S_SEND;
                end else begin
                    w_gap_cnt_n = r_gap_cnt - 2'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_valid_n = (w_state_n == S_SEND);
        w_x_n     = w_valid_n ? PATTERN[w_idx_n] : 1'b0;
        w_busy_n  = (w_state_n == S_SEND) || (w_state_n == S_GAP);
        w_done_n  = (w_state_n == S_DONE);
    end

    assign x     = r_x;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
